// File: rtl/sha_super_pipelined_block_loader.sv
`default_nettype none
// ============================================================================
// Module   : sha_super_pipelined_block_loader
// Brief    : Collects sixteen 32-bit message words into a SHA-256 schedule
//            window and presents it, with the initial hash state, as a
//            single-cycle strobe to a super-pipelined compression core.
// Revision : 1.0 - initial release
// ============================================================================

package sha_loader_pkg;
  // Working variables packed a..h from the most significant word down: [7] = a, [0] = h.
  typedef logic [7:0][31:0] HashState;
endpackage

module sha_super_pipelined_block_loader
  import sha_loader_pkg::*;
#(
  parameter int GAP = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       word_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  input  logic              first_block_i,
  input  HashState          chain_state_i,
  output HashState          state_o,
  output logic [15:0][31:0] W_o,
  output logic              valid_o,
  output logic              newblock_o,
  output logic [31:0]       block_count_o
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EMIT    = 2'd1,
    GAPWAIT = 2'd2
  } state_t;

  localparam HashState c_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [3:0] c_GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t            r_state;
  logic [3:0]        r_idx;
  logic [3:0]        r_gap_cnt;
  logic [15:0][31:0] r_slots;
  logic              r_first;
  HashState          r_chain;
  logic              r_ready;
  logic              r_valid;
  logic              r_newblock;
  logic [15:0][31:0] r_w;
  HashState          r_state_out;
  logic [31:0]       r_block_count;
  logic              w_xfer;

  assign w_xfer = word_valid_i & r_ready;

  // Ready is registered and only ever set when the next state is COLLECT,
  // so it is low throughout EMIT and GAPWAIT and for the cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= COLLECT;
      r_idx         <= 4'd0;
      r_gap_cnt     <= 4'd0;
      r_slots       <= '0;
      r_first       <= 1'b0;
      r_chain       <= '0;
      r_ready       <= 1'b0;
      r_valid       <= 1'b0;
      r_newblock    <= 1'b0;
      r_w           <= '0;
      r_state_out   <= '0;
      r_block_count <= 32'd0;
    end else begin
      r_valid    <= 1'b0;
      r_newblock <= 1'b0;
      case (r_state)
        COLLECT: begin
          r_ready <= 1'b1;
          if (w_xfer) begin
            r_slots[r_idx] <= word_i;
            r_idx          <= r_idx + 4'd1;
            if (r_idx == 4'd0) begin
              r_first <= first_block_i;
              r_chain <= chain_state_i;
            end
            if (r_idx == 4'd15) begin
              r_state <= EMIT;
              r_ready <= 1'b0;
            end
          end
        end
        EMIT: begin
          r_valid       <= 1'b1;
          r_newblock    <= r_first;
          r_w           <= r_slots;
          r_state_out   <= r_first ? c_IV : r_chain;
          r_block_count <= r_block_count + 32'd1;
          if (GAP > 0) begin
            r_state   <= GAPWAIT;
            r_gap_cnt <= c_GAP_LOAD;
            r_ready   <= 1'b0;
          end else begin
            r_state <= COLLECT;
            r_ready <= 1'b1;
          end
        end
        GAPWAIT: begin
          if (r_gap_cnt == 4'd0) begin
            r_state <= COLLECT;
            r_ready <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= COLLECT;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign word_ready_o  = r_ready;
  assign valid_o       = r_valid;
  assign newblock_o    = r_newblock;
  assign W_o           = r_w;
  assign state_o       = r_state_out;
  assign block_count_o = r_block_count;

endmodule

`default_nettype wire
